// File: rtl/argmax_cell_if.sv
// argmax_cell_if: groups the argmax_cell data paths into one bundle.
//   Input stream (from relu_cell): input_index, input_value, input_enable.
//   Result stream (to readout)   : output_class, output_max, output_valid,
//                                  output_ready (consumer back-pressure).
//   Status                       : overrun, index_error (sticky flags).
// Modports:
//   slave  - the argmax_cell side (consumes the stream, produces results)
//   master - the host/bench side (drives the stream, consumes results)
interface argmax_cell_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] input_index;
  logic [DATA_WIDTH-1:0] input_value;
  logic                  input_enable;
  logic [DATA_WIDTH-1:0] output_class;
  logic [DATA_WIDTH-1:0] output_max;
  logic                  output_valid;
  logic                  output_ready;
  logic                  overrun;
  logic                  index_error;

  modport slave (
    input  input_index, input_value, input_enable, output_ready,
    output output_class, output_max, output_valid, overrun, index_error
  );

  modport master (
    output input_index, input_value, input_enable, output_ready,
    input  output_class, output_max, output_valid, overrun, index_error
  );
endinterface

// File: rtl/argmax_cell.sv
// argmax_cell: tracks the maximum of each WEIGHT_AMOUNT-long vector of ReLU
// outputs and queues (class, max) results in a 2-entry FIFO for readout.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - argmax_cell_if.slave: input stream, result handshake, sticky flags
module argmax_cell #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_AMOUNT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  argmax_cell_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] LAST_INDEX = DATA_WIDTH'(WEIGHT_AMOUNT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] max_reg;
  logic [DATA_WIDTH-1:0] class_reg;
  logic [DATA_WIDTH-1:0] expected_reg;
  logic                  index_error_reg;

  logic [DATA_WIDTH-1:0] slot_class [2];
  logic [DATA_WIDTH-1:0] slot_max   [2];
  logic [1:0]            count_reg;
  logic                  rd_ptr_reg;
  logic                  wr_ptr_reg;
  logic                  overrun_reg;

  // Sample classification and the candidate running max
  logic                  start;
  logic                  step;
  logic                  bad;
  logic                  complete;
  logic [DATA_WIDTH-1:0] cand_max;
  logic [DATA_WIDTH-1:0] cand_class;

  always_comb begin
    start      = bus.input_enable && (bus.input_index == '0);
    step       = bus.input_enable && (state_reg == ACCUM) &&
                 (bus.input_index != '0) && (bus.input_index == expected_reg);
    // DISCARD silently drops nonzero indices, so only IDLE/ACCUM raise errors
    bad        = bus.input_enable && (bus.input_index != '0) &&
                 ((state_reg == IDLE) ||
                  ((state_reg == ACCUM) && (bus.input_index != expected_reg)));
    cand_max   = max_reg;
    cand_class = class_reg;
    if (start) begin
      cand_max   = bus.input_value;
      cand_class = '0;
    end else if (step && (bus.input_value > max_reg)) begin
      // strict compare: ties keep the earlier (lower) index
      cand_max   = bus.input_value;
      cand_class = bus.input_index;
    end
    complete = (start && (LAST_INDEX == '0)) ||
               (step && (bus.input_index == LAST_INDEX));
  end

  // Vector tracking FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      max_reg         <= '0;
      class_reg       <= '0;
      expected_reg    <= '0;
      index_error_reg <= 1'b0;
    end else begin
      if (start || step) begin
        max_reg   <= cand_max;
        class_reg <= cand_class;
      end
      if (complete) begin
        state_reg    <= IDLE;
        expected_reg <= '0;
      end else if (start) begin
        state_reg    <= ACCUM;
        expected_reg <= DATA_WIDTH'(1);
      end else if (step) begin
        expected_reg <= expected_reg + DATA_WIDTH'(1);
      end else if (bad) begin
        state_reg       <= DISCARD;
        index_error_reg <= 1'b1;
      end
    end
  end

  // Result FIFO. A push into a full FIFO is still accepted when the head is
  // popped on the same edge: the written slot is the one being vacated.
  logic       pop;
  logic       push_ok;
  logic [1:0] slot_we;

  assign pop     = (count_reg != 2'd0) && bus.output_ready;
  assign push_ok = complete && ((count_reg != 2'd2) || pop);

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot_we
    assign slot_we[gi] = push_ok && (wr_ptr_reg == 1'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        slot_class[i] <= '0;
        slot_max[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (slot_we[i]) begin
          slot_class[i] <= cand_class;
          slot_max[i]   <= cand_max;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= 2'd0;
      rd_ptr_reg  <= 1'b0;
      wr_ptr_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)     rd_ptr_reg <= ~rd_ptr_reg;
      if (push_ok && !pop)      count_reg <= count_reg + 2'd1;
      else if (!push_ok && pop) count_reg <= count_reg - 2'd1;
      if (complete && !push_ok) overrun_reg <= 1'b1;
    end
  end

  assign bus.output_valid = (count_reg != 2'd0);
  assign bus.output_class = bus.output_valid ? slot_class[rd_ptr_reg] : '0;
  assign bus.output_max   = bus.output_valid ? slot_max[rd_ptr_reg]   : '0;
  assign bus.overrun      = overrun_reg;
  assign bus.index_error  = index_error_reg;

endmodule

// File: tb/tb_argmax_cell.sv
// tb_argmax_cell: directed testbench for argmax_cell (DATA_WIDTH=32,
// WEIGHT_AMOUNT=3). Inputs change on the falling edge; outputs are
// observed on the falling edge.
module tb_argmax_cell;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  argmax_cell_if #(.DATA_WIDTH(32)) bus ();

  argmax_cell #(.DATA_WIDTH(32), .WEIGHT_AMOUNT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One enabled sample; called on a falling edge, returns on the next one
  task automatic drive(input logic [31:0] idx, input logic [31:0] val);
    bus.input_index  = idx;
    bus.input_value  = val;
    bus.input_enable = 1'b1;
    @(negedge clk);
    bus.input_enable = 1'b0;
    $display("[TB] sample idx=%0d val=%0d valid=%0b class=%0d max=%0d", idx, val,
             bus.output_valid, bus.output_class, bus.output_max);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.output_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.output_valid, bus.overrun, bus.index_error} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 000", {bus.output_valid, bus.overrun, bus.index_error});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.output_valid, bus.overrun, bus.index_error} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_flags: got %b expected 000", {bus.output_valid, bus.overrun, bus.index_error});
    end
    tests_run++;
    if ((bus.output_class !== 32'd0) || (bus.output_max !== 32'd0)) begin
      tests_failed++;
      $display("FAIL idle_data: got class=%0d max=%0d expected 0 0", bus.output_class, bus.output_max);
    end
  endtask

  task automatic test_basic();
    bus.output_ready = 1'b1;
    drive(0, 5); drive(1, 9); drive(2, 3);
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd1, 32'd9}) begin
      tests_failed++;
      $display("FAIL basic_result: got v=%0b class=%0d max=%0d expected v=1 class=1 max=9",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    @(negedge clk);
    tests_run++;
    if (bus.output_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pop: got valid=%0b expected 0", bus.output_valid);
    end
  endtask

  task automatic test_tie();
    drive(0, 7); drive(1, 7); drive(2, 0);
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd0, 32'd7}) begin
      tests_failed++;
      $display("FAIL tie_result: got v=%0b class=%0d max=%0d expected v=1 class=0 max=7",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    @(negedge clk);
    drive(0, 0); drive(1, 0); drive(2, 0);
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL zero_result: got v=%0b class=%0d max=%0d expected v=1 class=0 max=0",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    bus.output_ready = 1'b0;
    drive(0, 1); drive(1, 2); drive(2, 9);   // class 2, max 9
    drive(0, 8); drive(1, 2); drive(2, 3);   // class 0, max 8
    drive(0, 1); drive(1, 6); drive(2, 2);   // class 1, dropped
    tests_run++;
    if (bus.overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_flag: got %0b expected 1", bus.overrun);
    end
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd2, 32'd9}) begin
      tests_failed++;
      $display("FAIL overrun_head0: got v=%0b class=%0d max=%0d expected v=1 class=2 max=9",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    bus.output_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd0, 32'd8}) begin
      tests_failed++;
      $display("FAIL overrun_head1: got v=%0b class=%0d max=%0d expected v=1 class=0 max=8",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.output_valid, bus.overrun} !== 2'b01) begin
      tests_failed++;
      $display("FAIL overrun_drain: got valid=%0b overrun=%0b expected valid=0 overrun=1",
               bus.output_valid, bus.overrun);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(0, 1); drive(1, 2); drive(2, 9);   // A: class 2, max 9
    drive(0, 8); drive(1, 2); drive(2, 3);   // B: class 0, max 8
    drive(0, 1); drive(1, 6);
    bus.output_ready = 1'b1;                 // pop A on the edge that completes C
    drive(2, 2);                             // C: class 1, max 6
    tests_run++;
    if (bus.overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_edge_overrun: got %0b expected 0", bus.overrun);
    end
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd0, 32'd8}) begin
      tests_failed++;
      $display("FAIL same_edge_head: got v=%0b class=%0d max=%0d expected v=1 class=0 max=8",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd1, 32'd6}) begin
      tests_failed++;
      $display("FAIL same_edge_second: got v=%0b class=%0d max=%0d expected v=1 class=1 max=6",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    @(negedge clk);
    tests_run++;
    if (bus.output_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_edge_drain: got valid=%0b expected 0", bus.output_valid);
    end
  endtask

  task automatic test_index_error();
    drive(0, 4); drive(2, 8);
    tests_run++;
    if ({bus.index_error, bus.output_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL index_error_flag: got err=%0b valid=%0b expected err=1 valid=0",
               bus.index_error, bus.output_valid);
    end
    drive(0, 1); drive(1, 2); drive(2, 6);
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd2, 32'd6}) begin
      tests_failed++;
      $display("FAIL index_recover: got v=%0b class=%0d max=%0d expected v=1 class=2 max=6",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_vector();
    bus.output_ready = 1'b0;
    drive(0, 2); drive(1, 8); drive(2, 1);
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd1, 32'd8}) begin
      tests_failed++;
      $display("FAIL pre_reset_result: got v=%0b class=%0d max=%0d expected v=1 class=1 max=8",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    drive(0, 3); drive(1, 4);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max, bus.index_error, bus.overrun} !== 67'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%0b class=%0d max=%0d err=%0b ovr=%0b expected all 0",
               bus.output_valid, bus.output_class, bus.output_max, bus.index_error, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.output_ready = 1'b1;
    @(negedge clk);
    drive(2, 9);   // vector was dropped by reset, so this is out of sequence
    tests_run++;
    if ({bus.index_error, bus.output_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL dropped_vector: got err=%0b valid=%0b expected err=1 valid=0",
               bus.index_error, bus.output_valid);
    end
    drive(0, 2); drive(1, 1); drive(2, 1);
    tests_run++;
    if ({bus.output_valid, bus.output_class, bus.output_max} !== {1'b1, 32'd0, 32'd2}) begin
      tests_failed++;
      $display("FAIL post_reset_result: got v=%0b class=%0d max=%0d expected v=1 class=0 max=2",
               bus.output_valid, bus.output_class, bus.output_max);
    end
    @(negedge clk);
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    rst_n            = 1'b0;
    bus.input_index  = '0;
    bus.input_value  = '0;
    bus.input_enable = 1'b0;
    bus.output_ready = 1'b1;
    test_reset();
    test_basic();
    test_tie();
    test_overrun();
    test_back_to_back();
    test_index_error();
    test_reset_mid_vector();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
